// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes and read-adapter state encoding.
package axil_pkg;
  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } rd_state_t;
endpackage

// File: rtl/axil_reg_if_rd.sv
// axil_reg_if_rd: AXI4-Lite read slave driving a strobe/ack register read port,
// completing stalled accesses with SLVERR after TIMEOUT non-wait cycles.
module axil_reg_if_rd
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  rd_state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic [1:0] rresp_n;
  logic expired;
  logic unused_prot;
  assign unused_prot = ^s_axil_arprot;
  assign expired = TIMEOUT != 0 && timer == '0;
  always_comb begin
    state_n = state;
    timer_n = timer;
    addr_n  = reg_rd_addr;
    rdata_n = s_axil_rdata;
    rresp_n = s_axil_rresp;
    unique case (state)
      ST_RST: state_n = ST_IDLE;
      ST_IDLE: begin
        if (s_axil_arvalid) begin
          state_n = ST_ACCESS;
          addr_n  = s_axil_araddr & AMASK;
          timer_n = TLOAD;
        end
      end
      ST_ACCESS: begin
        // ack beats wait, and wait freezes the timer before expiry is considered
        if (reg_rd_ack) begin
          state_n = ST_RESP;
          rdata_n = reg_rd_data;
          rresp_n = AXIL_RESP_OKAY;
        end else if (!reg_rd_wait) begin
          if (expired) begin
            state_n = ST_RESP;
            rdata_n = '0;
            rresp_n = AXIL_RESP_SLVERR;
          end else if (timer != '0) begin
            timer_n = timer - TW'(1);
          end
        end
      end
      ST_RESP: state_n = s_axil_rready ? ST_IDLE : ST_RESP;
      default: state_n = ST_RST;
    endcase
  end
  // Handshake outputs are flopped from the next state so they are glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_RST;
      timer          <= '0;
      reg_rd_addr    <= '0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= AXIL_RESP_OKAY;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      reg_rd_en      <= 1'b0;
    end else begin
      state          <= state_n;
      timer          <= timer_n;
      reg_rd_addr    <= addr_n;
      s_axil_rdata   <= rdata_n;
      s_axil_rresp   <= rresp_n;
      s_axil_arready <= state_n == ST_IDLE;
      s_axil_rvalid  <= state_n == ST_RESP;
      reg_rd_en      <= state_n == ST_ACCESS;
    end
  end
endmodule

// File: tb/tb_axil_reg_if_rd.sv
// tb_axil_reg_if_rd: randomized scoreboard bench for the AXI-lite register read adapter.
module tb_axil_reg_if_rd;
  localparam int TO = 4;
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          n;
  } exp_t;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] s_axil_araddr = 0;
  logic [2:0]  s_axil_arprot = 0;
  logic        s_axil_arvalid = 0;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready = 1;
  logic [31:0] reg_rd_addr;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data = 0;
  logic        reg_rd_wait = 0;
  logic        reg_rd_ack = 0;
  int checks = 0;
  int errors = 0;
  exp_t sq[$];
  logic [31:0] aq[$];
  int ack_at = 0;
  bit [63:0] pw = 0;
  logic [31:0] pdata = 0;
  int last_n = 0;
  bit rr_rand = 0;

  axil_reg_if_rd #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the access ends at the ack, or at the TIMEOUT-th cycle that is neither wait nor ack
  function automatic exp_t model();
    exp_t e;
    int nw = 0;
    e.data = 0; e.resp = 2'b10; e.n = -1;
    for (int c = 1; c <= 200; c++) begin
      if (c == ack_at) begin
        e.data = pdata; e.resp = 2'b00; e.n = c;
        return e;
      end
      if (c < 64 && pw[c]) continue;
      nw++;
      if (nw == TO) begin
        e.data = 0; e.resp = 2'b10; e.n = c;
        return e;
      end
    end
    return e;
  endfunction

  // Register target: follows the current plan while reg_rd_en is high, drives junk otherwise
  initial begin
    int i = 0;
    forever begin
      @(posedge clk); #1;
      if (reg_rd_en) begin
        if (i == 0) begin
          if (aq.size() == 0) chk("addr_unexpected", 1, 0);
          else chk("reg_rd_addr", reg_rd_addr, aq.pop_front());
        end
        i++;
        reg_rd_wait = (i < 64) ? pw[i] : 1'b0;
        reg_rd_ack  = (i == ack_at);
        reg_rd_data = (i == ack_at) ? pdata : $urandom;
      end else begin
        if (i != 0) last_n = i;
        i = 0;
        reg_rd_wait = 1'($urandom);
        reg_rd_ack  = 1'($urandom);
        reg_rd_data = $urandom;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rr_rand) s_axil_rready = $urandom_range(0, 2) != 0;
  end

  // Monitor: pops one expectation per R handshake and checks held data while stalled
  initial begin
    bit stall = 0;
    logic [33:0] held = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) stall = 0;
      else begin
        if (stall && s_axil_rvalid) chk("r_stable", {s_axil_rdata, s_axil_rresp}, held);
        if (s_axil_rvalid && s_axil_rready) begin
          if (sq.size() == 0) chk("r_unexpected", 1, 0);
          else begin
            e = sq.pop_front();
            chk("rdata", s_axil_rdata, e.data);
            chk("rresp", s_axil_rresp, e.resp);
            chk("en_cycles", last_n, e.n);
          end
        end
        stall = s_axil_rvalid && !s_axil_rready;
        held = {s_axil_rdata, s_axil_rresp};
      end
    end
  end

  task automatic wait_ar();
    int t = 0;
    do begin @(negedge clk); t++; end while (!s_axil_arready && t < 100);
    if (t >= 100) chk("ar_timeout", 0, 1);
  endtask

  task automatic rd(input logic [31:0] a, input int ack, input bit [63:0] w, input logic [31:0] d);
    @(posedge clk); #1;
    ack_at = ack; pw = w; pdata = d;
    sq.push_back(model());
    aq.push_back(a & ~32'h3);
    s_axil_araddr = a; s_axil_arprot = 3'($urandom); s_axil_arvalid = 1;
    wait_ar();
    @(posedge clk); #1;
    s_axil_arvalid = 0; s_axil_araddr = $urandom;
    wait_ar();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int t;
    bit [63:0] w;
    repeat (3) @(negedge clk);
    chk("rst_arready", s_axil_arready, 0);
    chk("rst_rvalid", s_axil_rvalid, 0);
    chk("rst_rdata", s_axil_rdata, 0);
    chk("rst_rresp", s_axil_rresp, 0);
    chk("rst_en", reg_rd_en, 0);
    chk("rst_addr", reg_rd_addr, 0);
    rst = 0; #1;
    chk("arready_pre_edge", s_axil_arready, 0);
    @(negedge clk);
    chk("arready_after_edge", s_axil_arready, 1);

    rd(32'h0000_0013, 1, 0, 32'hDEAD_BEEF);
    rd($urandom, 0, 0, $urandom);
    rd($urandom, 11, 64'h7FE, 32'h1234_5678);
    rd($urandom, 4, 0, 32'hCAFE_F00D);

    // rready stalled with arvalid held: second read starts the cycle after the R handshake
    @(posedge clk); #1;
    s_axil_rready = 0;
    ack_at = 2; pw = 0; pdata = 32'hA5A5_0F0F;
    e = model();
    sq.push_back(e); sq.push_back(e);
    aq.push_back(32'h0000_0100); aq.push_back(32'h0000_0100);
    s_axil_araddr = 32'h0000_0102; s_axil_arvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_axil_rvalid && t < 100);
    if (t >= 100) chk("rvalid_timeout", 0, 1);
    repeat (5) begin
      chk("stall_arready", s_axil_arready, 0);
      chk("stall_rdata", s_axil_rdata, 32'hA5A5_0F0F);
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_axil_rready = 1;
    @(negedge clk);
    chk("arready_in_hs", s_axil_arready, 0);
    @(negedge clk);
    chk("arready_after_hs", s_axil_arready, 1);
    @(posedge clk); #1;
    s_axil_arvalid = 0;
    wait_ar();

    // reset in the middle of an access drops it with no R beat
    @(posedge clk); #1;
    ack_at = 0; pw = '1; pdata = 0;
    aq.push_back(32'h0000_0040);
    s_axil_araddr = 32'h0000_0041; s_axil_arvalid = 1;
    wait_ar();
    @(posedge clk); #1;
    s_axil_arvalid = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_en", reg_rd_en, 1);
    #2 rst = 1; #1;
    chk("mid_rst_en", reg_rd_en, 0);
    chk("mid_rst_rvalid", s_axil_rvalid, 0);
    chk("mid_rst_arready", s_axil_arready, 0);
    @(negedge clk);
    pw = 0;
    rst = 0;
    @(negedge clk);
    rd(32'h0000_0088, 2, 0, 32'h0BAD_CAFE);

    rr_rand = 1;
    repeat (40) begin
      w = 0;
      for (int c = 1; c < 14; c++) w[c] = $urandom_range(0, 2) == 0;
      rd($urandom, $urandom_range(0, 9), w, $urandom);
    end
    rr_rand = 0;
    s_axil_rready = 1;
    repeat (5) @(negedge clk);
    chk("sq_empty", sq.size(), 0);
    chk("aq_empty", aq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
